// File: rtl/branch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : branch_redirect_ctrl
// Purpose  : Sits between the EX-stage branch decoder and the fetch/decode
//            pipeline registers.
//            - On a taken branch, JAL or JALR it captures the redirect target.
//            - It then drives a one-state PC redirect, followed by a
//              parameterised drain window that squashes wrong-path
//              instructions.
//            - The global stall is honoured throughout.
//            - A saturating counter records the number of redirects.
// Ports    : clk, rst_n            - clock, async active-low reset
//            ex_valid, out_sel     - EX valid and decoder next-PC select
//            br_target, jalr_target- candidate redirect targets
//            stall                 - global pipeline stall
//            redirect_valid/pc     - fetch redirect request and address
//            flush_if_id/id_ex     - pipeline register squashes
//            misalign              - one-cycle pulse, target bit[1] set
//            busy                  - sequence in progress (state != RUN)
//            redirect_cnt          - saturating redirect count
// Revision : 1.0 - initial release
// ============================================================================
module branch_redirect_ctrl #(
  parameter int DRAIN_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic [1:0]       out_sel,
  input  logic [31:0]      br_target,
  input  logic [31:0]      jalr_target,
  input  logic             stall,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             misalign,
  output logic             busy,
  output logic [CNT_W-1:0] redirect_cnt
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_DRAIN    = 2'd2
  } state_t;

  localparam logic [2:0]       c_DRAIN_LOAD = 3'(DRAIN_CYCLES);
  localparam logic [CNT_W-1:0] c_CNT_MAX    = '1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_drain_cnt;
  logic [2:0]       w_drain_cnt_nxt;
  logic             w_accept;
  logic [31:0]      w_target;
  logic [31:0]      r_redirect_pc;
  logic             r_misalign;
  logic [CNT_W-1:0] r_redirect_cnt;

  // JALR clears bit 0 of the computed address.
  always_comb begin
    w_target = br_target;
    if (out_sel == 2'd2) begin
      w_target = jalr_target & 32'hFFFF_FFFE;
    end
  end

  // Decisions are only taken in RUN; in REDIRECT/DRAIN the EX instruction is
  // wrong-path, and a stalled decision is simply re-evaluated next cycle
  // with the held EX inputs. Select 3 (reserved) is ignored.
  assign w_accept = (r_state == ST_RUN) && ex_valid && !stall &&
                    ((out_sel == 2'd1) || (out_sel == 2'd2));

  always_comb begin
    w_state_nxt     = r_state;
    w_drain_cnt_nxt = r_drain_cnt;
    case (r_state)
      ST_RUN: begin
        if (w_accept) begin
          w_state_nxt = ST_REDIRECT;
        end
      end
      ST_REDIRECT: begin
        if (!stall) begin
          w_drain_cnt_nxt = c_DRAIN_LOAD;
          w_state_nxt     = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!stall) begin
          w_drain_cnt_nxt = r_drain_cnt - 3'd1;
          // Leave on the cycle the count steps down to zero; the <= also
          // guards against a zero load.
          if (r_drain_cnt <= 3'd1) begin
            w_drain_cnt_nxt = 3'd0;
            w_state_nxt     = ST_RUN;
          end
        end
      end
      default: begin
        w_state_nxt     = ST_RUN;
        w_drain_cnt_nxt = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_RUN;
      r_drain_cnt    <= 3'd0;
      r_redirect_pc  <= 32'd0;
      r_misalign     <= 1'b0;
      r_redirect_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= w_drain_cnt_nxt;
      r_misalign  <= w_accept && w_target[1];
      if (w_accept) begin
        r_redirect_pc <= w_target;
        if (r_redirect_cnt != c_CNT_MAX) begin
          r_redirect_cnt <= r_redirect_cnt + 1'b1;
        end
      end
    end
  end

  // Moore outputs decoded from the state; misalign is the registered pulse.
  assign redirect_valid = (r_state == ST_REDIRECT);
  assign flush_id_ex    = (r_state == ST_REDIRECT);
  assign flush_if_id    = (r_state != ST_RUN);
  assign busy           = (r_state != ST_RUN);
  assign redirect_pc    = r_redirect_pc;
  assign misalign       = r_misalign;
  assign redirect_cnt   = r_redirect_cnt;

endmodule
`default_nettype wire

// File: doc/branch_redirect_ctrl.md
# branch_redirect_ctrl

Sequencing controller that sits between the EX-stage branch decoder and the fetch/decode pipeline registers. It samples the decoder's 2-bit next-PC select each cycle and, on a taken branch, JAL or JALR, registers the redirect target. It then drives a PC redirect and squashes the wrong-path instructions in IF/ID and ID/EX over a fixed, parameterised drain window, honouring the global pipeline stall throughout. It also keeps a saturating count of redirects for performance observation.

## Interface
- DRAIN_CYCLES, 1, number of extra cycles (1..7) after the redirect cycle during which flush_if_id stays asserted
- CNT_W, 16, width of the redirect counter
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- ex_valid  input  1  instruction in EX is valid, not a bubble
- out_sel  input  2  decoder select: 0 = sequential, 1 = PC+imm target (branch taken / JAL), 2 = JALR target, 3 = reserved
- br_target  input  32  PC+imm target
- jalr_target  input  32  rs1+imm target
- stall  input  1  global pipeline stall (memory busy)
- redirect_valid  output  1  fetch must load redirect_pc
- redirect_pc  output  32  registered redirect address
- flush_if_id  output  1  squash IF/ID register
- flush_id_ex  output  1  squash ID/EX register
- misalign  output  1  one-cycle pulse: captured target bit[1] = 1
- busy  output  1  state != RUN
- redirect_cnt  output  CNT_W  saturating redirect count

## Operation
- States: RUN, REDIRECT, DRAIN. Encoding is free. Reset state is RUN.
- RUN, with ex_valid=1, stall=0 and out_sel in {1,2}:
  - Capture the target: br_target for select 1, or {jalr_target[31:1],1'b0} for select 2.
  - Go to REDIRECT.
  - Increment redirect_cnt unless it is all-ones.
  - If the captured target bit[1]=1, pulse misalign in the next cycle. The redirect still proceeds.
- RUN with out_sel=0 or 3, ex_valid=0, or stall=1: no action, stay in RUN. Select 3 is ignored silently.
- REDIRECT:
  - redirect_valid=1, flush_if_id=1, flush_id_ex=1.
  - If stall=1, hold the state and all outputs unchanged.
  - If stall=0, load drain counter = DRAIN_CYCLES and go to DRAIN.
- DRAIN:
  - flush_if_id=1. redirect_valid=0, flush_id_ex=0.
  - If stall=0, decrement the drain counter; when it reaches 0, go to RUN.
  - If stall=1, freeze the counter.
- ex_valid and out_sel are ignored in REDIRECT and DRAIN, because the EX instruction there is wrong-path.
- redirect_pc holds its last captured value outside REDIRECT.
- Outputs are Moore and decoded from the state, except misalign, which is a registered pulse.

## Timing
- Reset (async assert, any state): state=RUN, redirect_valid=0, redirect_pc=0, flush_if_id=0, flush_id_ex=0, misalign=0, busy=0, redirect_cnt=0. Deassertion takes effect at the next rising edge.
- Reset asserted mid-REDIRECT or mid-DRAIN aborts the sequence. There is no residual flush after reset.
- Latency: decision sampled at edge N, redirect_valid and flushes high in cycle N+1.
- Redirect occupancy with no stalls: 1 cycle REDIRECT plus DRAIN_CYCLES cycles DRAIN. busy is high for 1+DRAIN_CYCLES cycles.
- A new redirect cannot be accepted earlier than the first RUN cycle after DRAIN, so back-to-back taken branches are spaced by at least 2+DRAIN_CYCLES cycles.
- Stall rising in the same cycle as the RUN decision: no capture. The decision is re-evaluated on the first non-stalled cycle with the held EX inputs.
- Counter saturation: at all-ones, a redirect leaves the counter unchanged and no wrap occurs.

## Test plan
- Reset: drive rst_n=0 mid-DRAIN -> all outputs 0 immediately, state RUN, redirect_cnt=0.
- Taken branch: out_sel=1, br_target=0x0000_0100, ex_valid=1, DRAIN_CYCLES=1.
  - Next cycle: redirect_valid=1, redirect_pc=0x100, both flushes=1.
  - Following cycle: only flush_if_id=1.
  - Then RUN. redirect_cnt=1.
- JALR: jalr_target=0x0000_0203.
  - redirect_pc=0x0000_0202.
  - misalign pulses 1 cycle (bit[1]=1).
  - Second case: jalr_target=0x201 -> redirect_pc=0x200, no misalign.
- Stall: stall=1 in the decision cycle -> no redirect.
  - Release stall -> redirect one cycle later.
  - stall=1 for 3 cycles during REDIRECT -> redirect_valid held 4 cycles, redirect_cnt increments once.
- Squash window: out_sel=2 presented every cycle with DRAIN_CYCLES=3 -> redirects accepted every 5th cycle only.
- Saturation: preload via 2^CNT_W redirects (CNT_W=4 build) -> redirect_cnt sticks at 15. Also: out_sel=3 or out_sel=0 -> no redirect, count unchanged.
